ret_addr_stack: RTL and testbench
=================================

Name: ret_addr_stack

Overview:
- Hardware return-address stack for the RAT CPU.
- The branch-entry register captures a single 10-bit branch/call target. This block is the matching reader/restorer side:
  - CALL pushes the 10-bit return PC.
  - RET pops it back into the PC mux.
- Sits beside the PC/branch-entry logic and is driven by the control unit's push/pop strobes.
- Replaces scratch-RAM round trips for call/return addresses.

Parameters:
- ADDR_W, 10, width of a stored program address (matches the 10-bit PC).
- DEPTH, 8, number of stack entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- RS_CLK  in  1  system clock; all state updates on rising edge.
- RS_RST  in  1  synchronous, active-high reset.
- RS_PUSH  in  1  push RS_ADDR_IN this cycle (CALL).
- RS_ADDR_IN  in  ADDR_W  return address to push.
- RS_POP  in  1  pop top entry this cycle (RET).
- RS_ERR_CLR  in  1  clears sticky error flags.
- RS_TOP_ADDR  out  ADDR_W  current top-of-stack value; 0 when empty.
- RS_EMPTY  out  1  count == 0.
- RS_FULL  out  1  count == DEPTH.
- RS_COUNT  out  CNT_W  number of valid entries.
- RS_OVF  out  1  sticky: push attempted while full.
- RS_UNF  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (RS_RST=1 at an edge):
  - count=0, stack pointer=0, RS_OVF=0, RS_UNF=0.
  - Outputs: RS_EMPTY=1, RS_FULL=0, RS_TOP_ADDR=0.
  - Storage contents are don't-care.
  - Reset has priority over every other input, including mid-push/pop.
- Storage: register array plus write pointer sp; top entry = array[sp-1] mod DEPTH.
- RS_TOP_ADDR, RS_EMPTY, RS_FULL and RS_COUNT are combinational from registered state, with no input-to-output path.
  - The control unit samples RS_TOP_ADDR in the same cycle it asserts RS_POP.
- Push only (not full): array[sp] <= RS_ADDR_IN, sp++, count++. New top is visible the cycle after the edge.
- Pop only (not empty): sp--, count--. The entry is not cleared.
- Push and pop together, count>0: top entry is overwritten with RS_ADDR_IN; sp and count are unchanged.
- Push and pop together, empty:
  - Push is performed: count becomes 1, top = RS_ADDR_IN.
  - The pop is ignored and RS_UNF is set.
- Pop while empty: no state change; RS_UNF <= 1.
- Push while full (macro off): push is dropped; RS_OVF <= 1.
- Push and pop together while full: treated as a replace; no overflow.
- Pointer arithmetic wraps modulo DEPTH.
- count is saturating in [0, DEPTH].
- RS_ERR_CLR clears both flags at the next edge. If a new error occurs in the same cycle, the set wins.
- Latency: one cycle from strobe to updated outputs. No stall or handshake; strobes are single-cycle qualified.

Optional Feature:
- Macro: RET_ADDR_STACK_WRAP_EN.
- Defined: push while full overwrites the oldest entry (circular).
  - sp advances and count stays at DEPTH.
  - RS_OVF is still set, to record the loss.
  - The top becomes the new address.
- Undefined: push while full is dropped, as described in Behaviour; stack contents are unchanged.

Decomposition:
- Shared package rat_stack_pkg:
  - constant RAT_PC_W = 10.
  - typedef logic [RAT_PC_W-1:0] rat_addr_t.
  - typedef enum {RS_NOP, RS_PUSH_OP, RS_POP_OP, RS_REPL_OP} rs_op_t, decoded from {RS_PUSH, RS_POP}.
- No sub-module: the storage array, pointer and flag logic stay in one module. The array is inferred as registers, not BRAM.

Test Plan:
- Reset, then push 0x010, 0x020, 0x030 -> RS_COUNT=3, RS_TOP_ADDR=0x030. Three pops return 0x030, 0x020, 0x010, then RS_EMPTY=1 and RS_TOP_ADDR=0.
- DEPTH=8: push 0x100..0x107, then push 0x3FF -> RS_FULL=1, RS_OVF=1, top remains 0x107 (macro off). With the macro on, top=0x3FF and the oldest entry 0x100 is lost; popping 8 times ends at 0x101.
- Empty stack, pop -> RS_UNF=1, count stays 0. Assert RS_ERR_CLR -> RS_UNF=0 next cycle. RS_ERR_CLR together with a pop on empty -> RS_UNF stays 1.
- Push 0x055, then push+pop with 0x2AA together -> RS_COUNT=1, RS_TOP_ADDR=0x2AA.
- Empty stack, push+pop with 0x123 together -> count=1, top=0x123, RS_UNF=1.
- Push 0x011 and 0x022, then assert RS_RST in the same cycle as a push of 0x033 -> next cycle count=0, RS_EMPTY=1, flags=0, RS_TOP_ADDR=0.

Source files
------------

// File: rtl/rat_stack_pkg.sv
// rtl/rat_stack_pkg.sv - shared types and op decode for the RAT return-address stack
package rat_stack_pkg;

  // Width of a RAT program counter value
  localparam int RAT_PC_W = 10;

  typedef logic [RAT_PC_W-1:0] rat_addr_t;

  // Stack operation requested this cycle, decoded from {push, pop}
  typedef enum logic [1:0] {
    RS_NOP     = 2'b00,
    RS_PUSH_OP = 2'b01,
    RS_POP_OP  = 2'b10,
    RS_REPL_OP = 2'b11
  } rs_op_t;

  // Map the raw control-unit strobes onto a single operation code
  function automatic rs_op_t decode_op(input logic push, input logic pop);
    rs_op_t op;
    case ({push, pop})
      2'b10:   op = RS_PUSH_OP;
      2'b01:   op = RS_POP_OP;
      2'b11:   op = RS_REPL_OP;
      default: op = RS_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// rtl/ret_addr_stack.sv - CALL/RET return-address stack; RET_ADDR_STACK_WRAP_EN makes push-while-full circular
module ret_addr_stack
  import rat_stack_pkg::*;
#(
  parameter int ADDR_W = RAT_PC_W,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              RS_CLK,
  input  logic              RS_RST,
  input  logic              RS_PUSH,
  input  logic [ADDR_W-1:0] RS_ADDR_IN,
  input  logic              RS_POP,
  input  logic              RS_ERR_CLR,
  output logic [ADDR_W-1:0] RS_TOP_ADDR,
  output logic              RS_EMPTY,
  output logic              RS_FULL,
  output logic [CNT_W-1:0]  RS_COUNT,
  output logic              RS_OVF,
  output logic              RS_UNF
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Entry storage; kept as flops so the top can be read without a RAM cycle
  logic [ADDR_W-1:0] mem [DEPTH];

  // sp points at the next free slot; the top entry sits at sp-1
  logic [PTR_W-1:0] sp;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             unf;

  rs_op_t           op;
  logic             empty;
  logic             full;
  logic [PTR_W-1:0] top_idx;

  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] sp_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             ovf_set;
  logic             unf_set;

  // Decode the strobes and derive status from registered state only
  always_comb begin
    op      = decode_op(RS_PUSH, RS_POP);
    empty   = (count == '0);
    full    = (count == CNT_FULL);
    top_idx = sp - PTR_W'(1);
  end

  // Work out the write, pointer, count and error-set effects of this cycle's op
  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = sp;
    sp_nxt    = sp;
    count_nxt = count;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    case (op)
      RS_PUSH_OP: begin
        if (!full) begin
          wr_en     = 1'b1;
          wr_idx    = sp;
          sp_nxt    = sp + PTR_W'(1);
          count_nxt = count + CNT_W'(1);
        end else begin
          ovf_set = 1'b1;
`ifdef RET_ADDR_STACK_WRAP_EN
          // Full and circular: the slot at sp holds the oldest entry, so
          // writing there discards it while count stays saturated.
          wr_en  = 1'b1;
          wr_idx = sp;
          sp_nxt = sp + PTR_W'(1);
`endif
        end
      end
      RS_POP_OP: begin
        if (!empty) begin
          sp_nxt    = sp - PTR_W'(1);
          count_nxt = count - CNT_W'(1);
        end else begin
          unf_set = 1'b1;
        end
      end
      RS_REPL_OP: begin
        if (!empty) begin
          // Tail-call style: return address replaced in place
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else begin
          // Nothing to pop, so only the push half takes effect
          wr_en     = 1'b1;
          wr_idx    = sp;
          sp_nxt    = sp + PTR_W'(1);
          count_nxt = CNT_W'(1);
          unf_set   = 1'b1;
        end
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  // Storage write; contents are not reset since count gates visibility
  always_ff @(posedge RS_CLK) begin
    if (!RS_RST && wr_en) begin
      mem[wr_idx] <= RS_ADDR_IN;
    end
  end

  // Pointer, occupancy and sticky error flags; a new error beats a clear
  always_ff @(posedge RS_CLK) begin
    if (RS_RST) begin
      sp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      sp    <= sp_nxt;
      count <= count_nxt;
      ovf   <= (ovf & ~RS_ERR_CLR) | ovf_set;
      unf   <= (unf & ~RS_ERR_CLR) | unf_set;
    end
  end

  // Outputs come straight from state so the pop cycle can sample the top
  always_comb begin
    RS_TOP_ADDR = empty ? '0 : mem[top_idx];
    RS_EMPTY    = empty;
    RS_FULL     = full;
    RS_COUNT    = count;
    RS_OVF      = ovf;
    RS_UNF      = unf;
  end

endmodule

// File: tb/tb_ret_addr_stack.sv
// tb/tb_ret_addr_stack.sv - directed self-checking bench for ret_addr_stack
module tb_ret_addr_stack;

  logic       clk;
  logic       rst;
  logic       push;
  logic [9:0] addr_in;
  logic       pop;
  logic       err_clr;
  logic [9:0] top_addr;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       ovf;
  logic       unf;

  int checks = 0;
  int errors = 0;

  ret_addr_stack dut (
    .RS_CLK      (clk),
    .RS_RST      (rst),
    .RS_PUSH     (push),
    .RS_ADDR_IN  (addr_in),
    .RS_POP      (pop),
    .RS_ERR_CLR  (err_clr),
    .RS_TOP_ADDR (top_addr),
    .RS_EMPTY    (empty),
    .RS_FULL     (full),
    .RS_COUNT    (count),
    .RS_OVF      (ovf),
    .RS_UNF      (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one cycle of strobes, let the edge take them, sample 1 ns later
  task automatic cyc(input logic p_rst, input logic p_push, input logic p_pop,
                     input logic p_clr, input logic [9:0] a);
    rst     = p_rst;
    push    = p_push;
    pop     = p_pop;
    err_clr = p_clr;
    addr_in = a;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
    addr_in = '0;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 10'h0);
  endtask

  logic [9:0] pop_exp [8];

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; addr_in = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset state
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_top", top_addr, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);

    // Basic LIFO order
    cyc(0, 1, 0, 0, 10'h010);
    chk("p1_top", top_addr, 10'h010);
    cyc(0, 1, 0, 0, 10'h020);
    cyc(0, 1, 0, 0, 10'h030);
    chk("p3_count", count, 3);
    chk("p3_top", top_addr, 10'h030);
    chk("pop1_top", top_addr, 10'h030);
    cyc(0, 0, 1, 0, 10'h0);
    chk("pop2_top", top_addr, 10'h020);
    cyc(0, 0, 1, 0, 10'h0);
    chk("pop3_top", top_addr, 10'h010);
    cyc(0, 0, 1, 0, 10'h0);
    chk("pops_empty", empty, 1);
    chk("pops_top", top_addr, 0);
    chk("pops_unf", unf, 0);

    // Fill, replace while full, then overflow
    do_reset();
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 10'h100 + 10'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    chk("fill_top", top_addr, 10'h107);
    chk("fill_ovf", ovf, 0);
    cyc(0, 1, 1, 0, 10'h0AA);
    chk("repl_full_top", top_addr, 10'h0AA);
    chk("repl_full_ovf", ovf, 0);
    chk("repl_full_count", count, 8);
    cyc(0, 1, 0, 0, 10'h3FF);
    chk("ovf_flag", ovf, 1);
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 8);
`ifdef RET_ADDR_STACK_WRAP_EN
    chk("ovf_top", top_addr, 10'h3FF);
    pop_exp = '{10'h3FF, 10'h0AA, 10'h106, 10'h105, 10'h104, 10'h103, 10'h102, 10'h101};
`else
    chk("ovf_top", top_addr, 10'h0AA);
    pop_exp = '{10'h0AA, 10'h106, 10'h105, 10'h104, 10'h103, 10'h102, 10'h101, 10'h100};
`endif
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_top%0d", i), top_addr, pop_exp[i]);
      cyc(0, 0, 1, 0, 10'h0);
    end
    chk("drain_empty", empty, 1);
    chk("drain_top", top_addr, 0);
    chk("drain_unf", unf, 0);

    // Underflow, clear, and set-beats-clear
    do_reset();
    cyc(0, 0, 1, 0, 10'h0);
    chk("unf_set", unf, 1);
    chk("unf_count", count, 0);
    cyc(0, 0, 0, 1, 10'h0);
    chk("unf_clr", unf, 0);
    cyc(0, 0, 1, 1, 10'h0);
    chk("unf_set_wins", unf, 1);
    chk("unf_ovf_clear", ovf, 0);

    // Replace with one entry present
    do_reset();
    cyc(0, 1, 0, 0, 10'h055);
    cyc(0, 1, 1, 0, 10'h2AA);
    chk("repl_count", count, 1);
    chk("repl_top", top_addr, 10'h2AA);
    chk("repl_unf", unf, 0);

    // Push and pop together on an empty stack
    do_reset();
    cyc(0, 1, 1, 0, 10'h123);
    chk("pp_empty_count", count, 1);
    chk("pp_empty_top", top_addr, 10'h123);
    chk("pp_empty_unf", unf, 1);

    // Reset wins over a simultaneous push
    do_reset();
    cyc(0, 0, 1, 0, 10'h0);
    cyc(0, 1, 0, 0, 10'h011);
    cyc(0, 1, 0, 0, 10'h022);
    chk("pre_rst_count", count, 2);
    cyc(1, 1, 0, 0, 10'h033);
    chk("rstpush_count", count, 0);
    chk("rstpush_empty", empty, 1);
    chk("rstpush_unf", unf, 0);
    chk("rstpush_ovf", ovf, 0);
    chk("rstpush_top", top_addr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
